// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction sequencer feeding the processor core. Holds a small program
//   memory loaded while idle. On start it walks a program counter from 0 and
//   offers each instruction on a valid/ready handshake. After the last
//   instruction is accepted it pulses done for one cycle.
//
// Ports
//   i_clk          clock, all state updates on rising edge
//   i_rst          synchronous active-high reset
//   i_load_en      write i_load_data to mem[i_load_addr] (IDLE only)
//   i_load_addr    program memory write address
//   i_load_data    instruction word, bit order [0:7]
//   i_start        begin execution (IDLE only)
//   i_prog_len     instruction count, clipped to DEPTH, sampled with i_start
//   i_abort        terminate the running program
//   o_instr_out    instruction to core
//   o_instr_valid  o_instr_out holds a valid instruction
//   i_instr_ready  core accepts o_instr_out this cycle
//   o_pc           address of the instruction being fetched / issued
//   o_busy         high in FETCH and ISSUE
//   o_done         one-cycle pulse after the final handshake
//
// state  | meaning
// IDLE   | memory writable, waiting for start
// FETCH  | registering mem[pc] into o_instr_out
// ISSUE  | instruction offered, waiting for handshake
// DONE   | one-cycle done pulse, then back to IDLE

module instr_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [0:7]    i_load_data,
  input  logic          i_start,
  input  logic [AW:0]   i_prog_len,
  input  logic          i_abort,
  output logic [0:7]    o_instr_out,
  output logic          o_instr_valid,
  input  logic          i_instr_ready,
  output logic [AW-1:0] o_pc,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [0:7]    r_mem [DEPTH];
  logic [AW:0]   r_len;
  logic [AW-1:0] r_pc;
  logic [0:7]    r_instr;
  logic [AW:0]   w_len_clip;
  logic          w_hs;
  logic          w_last;

  assign w_len_clip = (i_prog_len > DEPTH_L) ? DEPTH_L : i_prog_len;
  assign w_hs       = (r_state == S_ISSUE) && i_instr_ready;
  // pc is widened so that pc+1 == DEPTH is representable for a full program
  assign w_last     = (({1'b0, r_pc} + (AW+1)'(1)) == r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (w_len_clip == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: if (w_hs) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort overrides everything outside IDLE, including a same-cycle handshake
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len <= w_len_clip;
            r_pc  <= '0;
          end
        end
        S_FETCH: r_instr <= r_mem[r_pc];
        S_ISSUE: begin
          if (w_hs && !w_last) r_pc <= r_pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Program memory has no reset so contents survive rst. A write in the same
  // cycle as start lands before FETCH reads it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_load_en && (r_state == S_IDLE)) r_mem[i_load_addr] <= i_load_data;
  end

  // instr_out is never zeroed outside reset: 8'h00 is a live opcode
  assign o_instr_out   = r_instr;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_pc          = r_pc;
  assign o_busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       i_rst, i_load_en, i_start, i_abort, i_instr_ready;
  logic [3:0] i_load_addr;
  logic [0:7] i_load_data;
  logic [4:0] i_prog_len;
  logic [0:7] o_instr_out;
  logic       o_instr_valid, o_busy, o_done;
  logic [3:0] o_pc;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [16];

  instr_fetch #(.DEPTH(16), .AW(4)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_start       (i_start),
    .i_prog_len    (i_prog_len),
    .i_abort       (i_abort),
    .o_instr_out   (o_instr_out),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_pc          (o_pc),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 32'(o_instr_out), 32'h00);
    check({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_done"},  32'(o_done), 32'd0);
    check({tag, "_pc"},    32'(o_pc), 32'd0);
  endtask

  task automatic load_word(input int addr, input logic [7:0] data);
    i_load_en   = 1'b1;
    i_load_addr = 4'(addr);
    i_load_data = data;
    model_mem[addr] = data;
    tick();
    i_load_en = 1'b0;
  endtask

  // Runs one program from IDLE. Expected instructions come from model_mem and
  // the clipped length; cycle numbering: the cycle right after the start edge is 1.
  task automatic run_prog(input int plen, input int ready_pct, input int stall_idx,
                          input int abort_at, input int exp_done_cyc, input bit bad_load,
                          input bit load_w_start, input logic [7:0] lw_data);
    int len, idx, cyc, stall_cnt;
    bit finished, via_done, rdy;
    len = (plen > 16) ? 16 : plen;
    i_start    = 1'b1;
    i_prog_len = 5'(plen);
    if (load_w_start) begin
      i_load_en   = 1'b1;
      i_load_addr = 4'd0;
      i_load_data = lw_data;
      model_mem[0] = lw_data;
    end
    tick();
    i_start   = 1'b0;
    i_load_en = 1'b0;
    idx = 0; cyc = 1; stall_cnt = 0; finished = 0; via_done = 0;
    while (!finished && cyc < 400) begin
      i_abort = 1'b0; i_load_en = 1'b0; i_instr_ready = 1'b0;
      if (o_done) begin
        check("done_count", 32'(idx), 32'(len));
        check("done_pc",    32'(o_pc), 32'((len == 0) ? 0 : len - 1));
        check("done_valid", 32'(o_instr_valid), 32'd0);
        check("done_busy",  32'(o_busy), 32'd0);
        if (exp_done_cyc > 0) check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        finished = 1; via_done = 1;
      end else begin
        check("busy", 32'(o_busy), 32'd1);
        if (ready_pct == 100 && stall_idx < 0)
          check("phase", 32'(o_instr_valid), 32'((cyc % 2) == 0));
        if (stall_cnt > 0 && idx == stall_idx)
          check("stall_valid", 32'(o_instr_valid), 32'd1);
        if (o_instr_valid) begin
          check("instr", 32'(o_instr_out), 32'(model_mem[idx & 15]));
          check("pc", 32'(o_pc), 32'(idx & 15));
          if (idx == stall_idx && stall_cnt < 5) begin
            stall_cnt++;
            rdy = 1'b0;
          end else begin
            rdy = ($urandom_range(0, 99) < ready_pct);
          end
          if (idx == abort_at) begin
            i_abort = 1'b1;
            rdy = 1'b1;
          end
          i_instr_ready = rdy;
          if (rdy) idx++;
        end
        if (bad_load && cyc == 3) begin
          i_load_en   = 1'b1;
          i_load_addr = 4'd1;
          i_load_data = 8'hFF;
        end
        tick();
        if (i_abort) begin
          check("abort_busy",  32'(o_busy), 32'd0);
          check("abort_valid", 32'(o_instr_valid), 32'd0);
          check("abort_done",  32'(o_done), 32'd0);
          finished = 1;
        end
      end
      cyc++;
    end
    i_abort = 1'b0; i_load_en = 1'b0; i_instr_ready = 1'b0;
    if (!finished) check("timeout", 32'd0, 32'd1);
    if (via_done) begin
      tick();
      check("done_pulse_width", 32'(o_done), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);
    end else if (finished) begin
      tick();
      check("abort_no_done", 32'(o_done), 32'd0);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
    i_start = 1'b0; i_prog_len = '0; i_abort = 1'b0; i_instr_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    i_rst = 1'b0;

    load_word(0, 8'hA5);
    load_word(1, 8'h3C);
    load_word(2, 8'h40);
    load_word(3, 8'hF1);
    for (int a = 4; a < 16; a++) load_word(a, 8'($urandom));

    // basic 4-instruction program, ready always high
    run_prog(4, 100, -1, -1, 9, 1'b0, 1'b0, 8'h00);
    // 5-cycle stall on the second instruction
    run_prog(4, 100, 1, -1, -1, 1'b0, 1'b0, 8'h00);
    // zero-length program
    run_prog(0, 100, -1, -1, 1, 1'b0, 1'b0, 8'h00);
    // oversize length clipped to DEPTH
    run_prog(31, 100, -1, -1, 33, 1'b0, 1'b0, 8'h00);
    // full memory with random backpressure
    run_prog(16, 40, -1, -1, -1, 1'b0, 1'b0, 8'h00);
    // abort together with a handshake on instruction 2, then rerun
    run_prog(4, 100, -1, 2, -1, 1'b0, 1'b0, 8'h00);
    run_prog(4, 100, -1, -1, 9, 1'b0, 1'b0, 8'h00);
    // write while busy is ignored; rerun must still see 8'h3C
    run_prog(4, 100, -1, -1, 9, 1'b1, 1'b0, 8'h00);
    run_prog(4, 70, -1, -1, -1, 1'b0, 1'b0, 8'h00);

    // reset during ISSUE
    i_start = 1'b1; i_prog_len = 5'd4;
    tick();
    i_start = 1'b0;
    tick();
    check("pre_rst_valid", 32'(o_instr_valid), 32'd1);
    i_rst = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    i_rst = 1'b0;
    tick();
    check("post_rst_done", 32'(o_done), 32'd0);
    run_prog(4, 100, -1, -1, 9, 1'b0, 1'b0, 8'h00);

    // load and start in the same cycle, then a random program of random length
    run_prog(3, 100, -1, -1, 7, 1'b0, 1'b1, 8'($urandom));
    for (int a = 0; a < 16; a++) load_word(a, 8'($urandom));
    run_prog($urandom_range(1, 16), 60, -1, -1, -1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
